// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } mdu_mode_t;

   localparam int W_ITER = 32;

endpackage

// File: rtl/mdu_shift_core.sv
// One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
module mdu_shift_core
   import mdu_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int CW   = $clog2(XLEN + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            start,
   input  mdu_mode_t       mode,
   input  logic [CW-1:0]   iter,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] init_lo,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            done
);

   logic [XLEN-1:0] opa_q;
   mdu_mode_t       mode_q;
   logic [CW-1:0]   cnt;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   rsh;
   logic [XLEN:0]   diff;
   logic [XLEN-1:0] hi_nx;
   logic [XLEN-1:0] lo_nx;

   // Multiply: hi accumulates, {hi,lo} shifts right consuming multiplier bits from lo.
   // Divide: {hi,lo} shifts left, hi is the partial remainder, quotient bits enter lo.
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, opa_q} : '0);
      rsh  = {hi, lo[XLEN-1]};
      diff = rsh - {1'b0, opa_q};
      if (mode_q == MODE_MUL) begin
         hi_nx = sum[XLEN:1];
         lo_nx = {sum[0], lo[XLEN-1:1]};
      end else if (!diff[XLEN]) begin
         hi_nx = diff[XLEN-1:0];
         lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
         hi_nx = rsh[XLEN-1:0];
         lo_nx = {lo[XLEN-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi     <= '0;
         lo     <= '0;
         opa_q  <= '0;
         mode_q <= MODE_MUL;
         cnt    <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (start) begin
         hi     <= '0;
         lo     <= init_lo;
         opa_q  <= opa;
         mode_q <= mode;
         cnt    <= iter;
      end else if (cnt != '0) begin
         hi  <= hi_nx;
         lo  <= lo_nx;
         cnt <= cnt - CW'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mdu.sv
// RV64M multiply/divide unit: operand prep, special cases, sign fix-up and W extension
// around an iterative shift core. Handshakes: a transfer occurs on a rising edge where valid & ready.
module mdu
   import mdu_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int SUPPORT_W = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic            is_word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN + 1);

   function automatic logic [XLEN-1:0] wext(input logic [31:0] v, input logic s);
      logic [XLEN-1:0] r;
      r       = {XLEN{s & v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   mdu_state_t      state;
   mdu_op_t         op, op_q;
   logic            word, word_q, neg_q, neg_r;
   logic            is_div, a_sgn, b_sgn, sa, sb;
   logic            div_zero, div_ovf, illegal, special;
   logic [XLEN-1:0] op1, op2, mag1, mag2, minv, spec_res;
   logic [XLEN-1:0] core_opa, core_lo, core_hi, core_lo_out;
   logic [CW-1:0]   core_iter;
   logic            core_done, core_start;
   mdu_mode_t       core_mode;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] quo, rem, fin;

   assign op = mdu_op_t'(funct3);

   always_comb begin
      word   = (SUPPORT_W != 0) && is_word;
      is_div = funct3[2];
      a_sgn  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_sgn  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      op1    = word ? wext(src1[31:0], a_sgn) : src1;
      op2    = word ? wext(src2[31:0], b_sgn) : src2;
      sa     = a_sgn & op1[XLEN-1];
      sb     = b_sgn & op2[XLEN-1];
      mag1   = sa ? -op1 : op1;
      mag2   = sb ? -op2 : op2;
      // Most-negative value at the operating width; W operands are already sign-extended.
      minv   = word ? wext(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = is_div && (op2 == '0);
      div_ovf  = is_div && a_sgn && (op1 == minv) && (op2 == '1);
      illegal  = word && (funct3 == 3'd1 || funct3 == 3'd2 || funct3 == 3'd3);
      special  = div_zero || div_ovf || illegal;
      if (illegal)
         spec_res = '0;
      else if (div_zero)
         spec_res = funct3[1] ? op1 : '1;
      else
         spec_res = funct3[1] ? '0 : op1;
      if (word)
         spec_res = wext(spec_res[31:0], 1'b1);
   end

   // Divide with 32 iterations needs the dividend at the top so its MSB is consumed first.
   assign core_mode  = is_div ? MODE_DIV : MODE_MUL;
   assign core_iter  = word ? CW'(W_ITER) : CW'(XLEN);
   assign core_opa   = is_div ? mag2 : mag1;
   assign core_lo    = is_div ? (word ? (mag1 << (XLEN - W_ITER)) : mag1) : mag2;
   assign core_start = (state == IDLE) && in_valid && !flush && !special;

   mdu_shift_core #(.XLEN(XLEN), .CW(CW)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .start   (core_start),
      .mode    (core_mode),
      .iter    (core_iter),
      .opa     (core_opa),
      .init_lo (core_lo),
      .hi      (core_hi),
      .lo      (core_lo_out),
      .done    (core_done)
   );

   always_comb begin
      prod = {core_hi, core_lo_out};
      // After 32 multiply steps the product sits 32 bits up in the accumulator.
      if (word_q)
         prod = prod >> (XLEN - W_ITER);
      if (neg_q)
         prod = -prod;
      quo = neg_q ? -core_lo_out : core_lo_out;
      rem = neg_r ? -core_hi : core_hi;
      case (op_q)
         OP_MUL:                       fin = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fin = quo;
         default:                      fin = rem;
      endcase
      if (word_q)
         fin = wext(fin[31:0], 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         op_q      <= OP_MUL;
         word_q    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_q     <= op;
               word_q   <= word;
               neg_q    <= sa ^ sb;
               neg_r    <= sa;
               in_ready <= 1'b0;
               if (special) begin
                  result    <= spec_res;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  state <= BUSY;
               end
            end
            BUSY: if (core_done) begin
               result    <= fin;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: arithmetic reference model, per-cycle result scoreboard, latency and control checks.
module tb_mdu;

   localparam int XLEN = 64;
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [2:0]      funct3 = 3'd0;
   logic            is_word = 1'b0;
   logic [XLEN-1:0] src1 = '0;
   logic [XLEN-1:0] src2 = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] result;

   int checks = 0;
   int errors = 0;
   logic [XLEN-1:0] exp_q[$];

   mdu #(.XLEN(XLEN), .SUPPORT_W(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct3    (funct3),
      .is_word   (is_word),
      .src1      (src1),
      .src2      (src2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [127:0] pa, pb, p;
      logic [63:0] r;
      logic signed [63:0] s64a, s64b;
      logic [31:0] a32, b32, r32;
      logic signed [31:0] s32a, s32b;
      r = '0;
      if (w) begin
         a32 = a[31:0]; b32 = b[31:0]; s32a = a32; s32b = b32;
         r32 = '0;
         case (f)
            3'd0: r32 = a32 * b32;
            3'd4: if (b32 == 0) r32 = '1;
                  else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                  else r32 = s32a / s32b;
            3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
            3'd6: if (b32 == 0) r32 = a32;
                  else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                  else r32 = s32a % s32b;
            3'd7: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
            default: r32 = '0;
         endcase
         r = {{32{r32[31]}}, r32};
      end else begin
         s64a = a; s64b = b;
         case (f)
            3'd0, 3'd1, 3'd2, 3'd3: begin
               pa = (f == 3'd1 || f == 3'd2) ? {{64{a[63]}}, a} : {64'b0, a};
               pb = (f == 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
               p  = pa * pb;
               r  = (f == 3'd0) ? p[63:0] : p[127:64];
            end
            3'd4: if (b == 0) r = '1;
                  else if (a == MIN64 && b == ALL1) r = a;
                  else r = s64a / s64b;
            3'd5: if (b == 0) r = '1; else r = a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == MIN64 && b == ALL1) r = '0;
                  else r = s64a % s64b;
            default: if (b == 0) r = a; else r = a % b;
         endcase
      end
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", {63'b0, out_valid}, 64'd0);
            else check("model_result", result, exp_q[0]);
         end
         if (flush) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(funct3, is_word, src1, src2));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // lat counts edges after the accepting edge; 0 means done on the accepting edge itself.
   task automatic do_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] lit, input int lat,
                        input int hold);
      int  e;
      logic ir_ok;
      check("model_pin", model(f, w, a, b), lit);
      e = 0;
      while (!in_ready && e < 200) begin @(posedge clk); #1; e++; end
      funct3 = f; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      e = 0; ir_ok = 1'b1;
      while (!out_valid && e < 200) begin
         if (in_ready) ir_ok = 1'b0;
         @(posedge clk); #1; e++;
      end
      check("latency", 64'(e), 64'(lat));
      check("in_ready_busy", {63'b0, ir_ok}, 64'd1);
      check("result_lit", result, lit);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", {63'b0, out_valid}, 64'd1);
         check("hold_result", result, lit);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("pop_valid", {63'b0, out_valid}, 64'd0);
      check("pop_ready", {63'b0, in_ready}, 64'd1);
   endtask

   task automatic start_raw(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      funct3 = f; is_word = 1'b0; src1 = a; src2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic seen;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {63'b0, in_ready}, 64'd1);
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_result", result, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
      do_op(3'd3, 1'b0, ALL1, 64'd2, 64'd1, 65, 5);
      do_op(3'd1, 1'b0, ALL1, ALL1, 64'd0, 65, 0);
      do_op(3'd2, 1'b0, ALL1, 64'd2, ALL1, 65, 0);
      do_op(3'd5, 1'b0, 64'd5, 64'd0, ALL1, 0, 0);
      do_op(3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 0, 0);
      do_op(3'd4, 1'b0, MIN64, ALL1, MIN64, 0, 0);
      do_op(3'd6, 1'b0, MIN64, ALL1, 64'd0, 0, 2);
      do_op(3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
      do_op(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, ALL1, 33, 0);
      do_op(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
      do_op(3'd1, 1'b1, 64'd5, 64'd6, 64'd0, 0, 0);
      do_op(3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'hAAAA_0000_0000_0000, ALL1, 0, 0);
      do_op(3'd7, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 0, 0);
      do_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 0);
      do_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1, 65, 0);
      do_op(3'd5, 1'b0, ALL1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65, 0);
      do_op(3'd7, 1'b0, ALL1, 64'h10, 64'hF, 65, 0);

      // flush in BUSY
      start_raw(3'd0, 64'd3, 64'd9);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_out_valid", {63'b0, out_valid}, 64'd0);
      check("flush_in_ready", {63'b0, in_ready}, 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("flush_never_valid", {63'b0, seen}, 64'd0);
      do_op(3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);

      // flush in IDLE blocks acceptance
      funct3 = 3'd5; src1 = 64'd9; src2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_ready", {63'b0, in_ready}, 64'd1);
      repeat (3) @(posedge clk);
      #1 check("flush_idle_valid", {63'b0, out_valid}, 64'd0);

      // asynchronous reset mid-BUSY
      start_raw(3'd0, 64'd3, 64'd9);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_in_ready", {63'b0, in_ready}, 64'd1);
      check("arst_out_valid", {63'b0, out_valid}, 64'd0);
      check("arst_result", result, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);

      repeat (3) @(posedge clk);
      #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
